sim_mem_htif: RTL and testbench

Parametrised simulation memory and HTIF monitor that sits between a CPU core and the testbench top. It provides a shared instruction/data memory. The instruction port reads combinationally. The data port has configurable fixed latency, byte-enabled stores, a bounded number of outstanding loads with backpressure, and out-of-range error reporting. It also detects tohost termination and enforces a cycle timeout. It replaces the fixed 1-cycle, always-ready data memory model used by earlier CPU benches.

---
 rtl/sim_mem_htif.sv | 139 +++++++++++++
 tb/tb_sim_mem_htif.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_htif.sv
// Simulation memory with a combinational fetch port, a fixed-latency data port with
// bounded outstanding loads, and HTIF tohost / cycle-timeout monitoring.
module sim_mem_htif #(
    parameter int          MEM_SIZE_WORDS  = 16384,
    parameter logic [31:0] MEM_BASE        = 32'h8000_0000,
    parameter int          DMEM_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] TOHOST_ADDR     = 32'h8000_1000,
    parameter int          TIMEOUT_CYCLES  = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    input  logic        dmem_req_valid,
    output logic        dmem_req_ready,
    input  logic        dmem_req_we,
    input  logic [3:0]  dmem_req_be,
    input  logic [31:0] dmem_req_addr,
    input  logic [31:0] dmem_req_data,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_resp_data,
    output logic        dmem_resp_err,
    output logic        test_done,
    output logic        test_pass,
    output logic [31:0] test_code,
    output logic        timeout,
    output logic [31:0] cycle_count
);

    localparam int          AW      = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
    // One bit wider so a window ending at the top of the address space cannot wrap.
    localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + 33'(4 * MEM_SIZE_WORDS);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    function automatic logic in_range(input logic [31:0] a);
        return (a >= MEM_BASE) && ({1'b0, a} < MEM_END);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - MEM_BASE) >> 2);
    endfunction

    logic [31:0] mem_q [MEM_SIZE_WORDS];

    logic          i_in, d_in;
    logic [AW-1:0] i_idx, d_idx;
    logic          acc, st_en, ld_acc;

    assign i_in      = in_range(imem_addr);
    assign i_idx     = word_idx(imem_addr);
    assign imem_data = i_in ? mem_q[i_idx] : 32'h0;

    assign d_in   = in_range(dmem_req_addr);
    assign d_idx  = word_idx(dmem_req_addr);
    assign acc    = dmem_req_valid && dmem_req_ready && !reset;
    assign st_en  = acc && dmem_req_we && d_in;
    assign ld_acc = acc && !dmem_req_we;

    // Memory is deliberately not reset so preloaded images survive a reset.
    always_ff @(posedge clock) begin
        if (st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_req_be[b]) mem_q[d_idx][8*b +: 8] <= dmem_req_data[8*b +: 8];
            end
        end
    end

    logic [DMEM_LATENCY-1:0]       vld_q;
    logic [DMEM_LATENCY-1:0][31:0] rdat_q;
    logic [DMEM_LATENCY-1:0]       rerr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= '0;
            rdat_q <= '0;
            rerr_q <= '0;
        end else begin
            vld_q[0]  <= ld_acc;
            rdat_q[0] <= (ld_acc && d_in) ? mem_q[d_idx] : 32'h0;
            rerr_q[0] <= ld_acc && !d_in;
            for (int s = 1; s < DMEM_LATENCY; s++) begin
                vld_q[s]  <= vld_q[s-1];
                rdat_q[s] <= rdat_q[s-1];
                rerr_q[s] <= rerr_q[s-1];
            end
        end
    end

    // Every occupied stage counts as in flight, including the one presenting a response.
    assign dmem_req_ready  = $countones(vld_q) < MAX_OUTSTANDING;
    assign dmem_resp_valid = vld_q[DMEM_LATENCY-1];
    assign dmem_resp_data  = rdat_q[DMEM_LATENCY-1];
    assign dmem_resp_err   = rerr_q[DMEM_LATENCY-1];

    logic        done_q, done_d, pass_q, pass_d, to_q, to_d;
    logic [31:0] code_q, code_d, cnt_q, cnt_d;

    always_comb begin
        done_d = done_q;
        pass_d = pass_q;
        code_d = code_q;
        to_d   = to_q;
        cnt_d  = cnt_q;
        // The counter stops on the timeout cycle itself, so it reads TIMEOUT_CYCLES-1.
        if (!done_q && !to_q) begin
            if (cnt_q == TO_LAST) to_d = 1'b1;
            else                  cnt_d = cnt_q + 32'd1;
        end
        if (acc && dmem_req_we && (dmem_req_addr == TOHOST_ADDR) && !done_q) begin
            done_d = 1'b1;
            code_d = dmem_req_data;
            pass_d = (dmem_req_data == 32'd1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
            code_q <= 32'h0;
            to_q   <= 1'b0;
            cnt_q  <= 32'h0;
        end else begin
            done_q <= done_d;
            pass_q <= pass_d;
            code_q <= code_d;
            to_q   <= to_d;
            cnt_q  <= cnt_d;
        end
    end

    assign test_done   = done_q;
    assign test_pass   = pass_q;
    assign test_code   = code_q;
    assign timeout     = to_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_sim_mem_htif.sv
// Bench for sim_mem_htif: a 1-cycle instance (vectors, random traffic, tohost) and a
// 4-cycle / 2-outstanding instance (pipelining, timeout, reset with loads in flight).
module tb_sim_mem_htif;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] TOHOST = 32'h8000_1000;
    localparam int LAT0 = 1, MAX0 = 1, MEM0 = 2048, TMO0 = 100000;
    localparam int LAT1 = 4, MAX1 = 2, MEM1 = 1024, TMO1 = 50;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst0 = 1'b1, rst1 = 1'b1, sel = 1'b0;
    logic        vld = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0, wdata = '0, iaddr = BASE;

    logic        rdy0, rv0, re0, td0, tp0, to0, rdy1, rv1, re1, td1, tp1, to1;
    logic [31:0] im0, rd0, tc0, cc0, im1, rd1, tc1, cc1;

    sim_mem_htif #(.MEM_SIZE_WORDS(MEM0), .MEM_BASE(BASE), .DMEM_LATENCY(LAT0),
                   .MAX_OUTSTANDING(MAX0), .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(TMO0)) u0 (
        .clock(clock), .reset(rst0), .imem_addr(iaddr), .imem_data(im0),
        .dmem_req_valid(vld && !sel), .dmem_req_ready(rdy0), .dmem_req_we(we),
        .dmem_req_be(be), .dmem_req_addr(addr), .dmem_req_data(wdata),
        .dmem_resp_valid(rv0), .dmem_resp_data(rd0), .dmem_resp_err(re0),
        .test_done(td0), .test_pass(tp0), .test_code(tc0), .timeout(to0), .cycle_count(cc0));

    sim_mem_htif #(.MEM_SIZE_WORDS(MEM1), .MEM_BASE(BASE), .DMEM_LATENCY(LAT1),
                   .MAX_OUTSTANDING(MAX1), .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(TMO1)) u1 (
        .clock(clock), .reset(rst1), .imem_addr(iaddr), .imem_data(im1),
        .dmem_req_valid(vld && sel), .dmem_req_ready(rdy1), .dmem_req_we(we),
        .dmem_req_be(be), .dmem_req_addr(addr), .dmem_req_data(wdata),
        .dmem_resp_valid(rv1), .dmem_resp_data(rd1), .dmem_resp_err(re1),
        .test_done(td1), .test_pass(tp1), .test_code(tc1), .timeout(to1), .cycle_count(cc1));

    logic        c_rdy, c_rv, c_re, c_td, c_tp, c_to;
    logic [31:0] c_im, c_rd, c_tc, c_cc;
    assign c_rdy = sel ? rdy1 : rdy0;
    assign c_rv  = sel ? rv1  : rv0;
    assign c_re  = sel ? re1  : re0;
    assign c_td  = sel ? td1  : td0;
    assign c_tp  = sel ? tp1  : tp0;
    assign c_to  = sel ? to1  : to0;
    assign c_im  = sel ? im1  : im0;
    assign c_rd  = sel ? rd1  : rd0;
    assign c_tc  = sel ? tc1  : tc0;
    assign c_cc  = sel ? cc1  : cc0;

    // Reference model: in-flight loads as a queue with ages, memory as a word array.
    typedef struct { logic [31:0] d; logic e; int age; } ld_t;
    ld_t         mq[$];
    logic [31:0] mm [2048];
    bit          mw [2048];
    int          m_cnt;
    bit          m_done, m_pass, m_to, m_acc;
    logic [31:0] m_code;
    int          errors = 0, checks = 0;

    function automatic int lat();  return sel ? LAT1 : LAT0; endfunction
    function automatic int mx();   return sel ? MAX1 : MAX0; endfunction
    function automatic int tmo();  return sel ? TMO1 : TMO0; endfunction
    function automatic int memw(); return sel ? MEM1 : MEM0; endfunction
    function automatic bit inr(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * memw()));
    endfunction
    function automatic int widx(input logic [31:0] a); return int'((a - BASE) >> 2); endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", n, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst);
        int  w;
        ld_t l;
        m_acc = 1'b0;
        if (rst) begin
            mq.delete();
            m_cnt = 0; m_done = 0; m_pass = 0; m_to = 0; m_code = '0;
            return;
        end
        m_acc = vld && (mq.size() < mx());
        foreach (mq[i]) mq[i].age++;
        if (mq.size() > 0 && mq[0].age == lat()) void'(mq.pop_front());
        if (!m_done && !m_to) begin
            if (m_cnt == tmo() - 1) m_to = 1'b1;
            else                    m_cnt++;
        end
        if (m_acc) begin
            w = widx(addr);
            if (we) begin
                if (inr(addr)) begin
                    for (int b = 0; b < 4; b++) if (be[b]) mm[w][8*b +: 8] = wdata[8*b +: 8];
                    mw[w] = mw[w] || (be == 4'hF);
                end
                if (addr == TOHOST && !m_done) begin
                    m_done = 1'b1; m_code = wdata; m_pass = (wdata == 32'd1);
                end
            end else begin
                l.age = 0;
                l.d   = inr(addr) ? mm[w] : 32'h0;
                l.e   = !inr(addr);
                mq.push_back(l);
            end
        end
    endtask

    task automatic check_out();
        bit ev;
        ev = (mq.size() > 0) && (mq[0].age == lat() - 1);
        chk1("ready", c_rdy, mq.size() < mx());
        chk1("resp_valid", c_rv, ev);
        if (ev) begin
            chk("resp_data", c_rd, mq[0].d);
            chk1("resp_err", c_re, mq[0].e);
        end
        chk1("test_done", c_td, m_done);
        chk1("test_pass", c_tp, m_pass);
        chk("test_code", c_tc, m_code);
        chk1("timeout", c_to, m_to);
        chk("cycle_count", c_cc, 32'(m_cnt));
        if (!inr(iaddr))          chk("imem_oor", c_im, 32'h0);
        else if (mw[widx(iaddr)]) chk("imem", c_im, mm[widx(iaddr)]);
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge(sel ? rst1 : rst0);
        @(negedge clock);
        check_out();
    endtask

    task automatic drive(input logic v, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        vld = v; we = w; be = b; addr = a; wdata = d;
    endtask

    task automatic chk_reset(input string p);
        chk1({p, "_ready"}, c_rdy, 1'b1);
        chk1({p, "_resp_valid"}, c_rv, 1'b0);
        chk({p, "_resp_data"}, c_rd, 32'h0);
        chk1({p, "_resp_err"}, c_re, 1'b0);
        chk1({p, "_done"}, c_td, 1'b0);
        chk1({p, "_pass"}, c_tp, 1'b0);
        chk({p, "_code"}, c_tc, 32'h0);
        chk1({p, "_timeout"}, c_to, 1'b0);
        chk({p, "_cycle_count"}, c_cc, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] a, d, exp;
        logic        err;
    } vec_t;
    vec_t tv[14];

    int acc_e[$], rsp_e[$];
    int exp_acc[5] = '{0, 1, 5, 6, 10};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mw[i] = 1'b0;
        tv[0]  = '{1'b1, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tv[1]  = '{1'b0, 4'h0, 32'h8000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tv[2]  = '{1'b1, 4'hF, 32'h8000_0200, 32'h1122_3344, 32'h1122_3344, 1'b0};
        tv[3]  = '{1'b1, 4'h5, 32'h8000_0200, 32'hAABB_CCDD, 32'h11BB_33DD, 1'b0};
        tv[4]  = '{1'b0, 4'h0, 32'h8000_0200, 32'h0,         32'h11BB_33DD, 1'b0};
        tv[5]  = '{1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0,         32'h0,         1'b1};
        tv[6]  = '{1'b0, 4'h0, 32'h8000_2000, 32'h0,         32'h0,         1'b1};
        tv[7]  = '{1'b1, 4'hF, 32'h8000_2000, 32'h5566_7788, 32'h0,         1'b0};
        tv[8]  = '{1'b1, 4'hF, 32'h8000_1FFC, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        tv[9]  = '{1'b0, 4'h0, 32'h8000_1FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
        tv[10] = '{1'b0, 4'h0, 32'h8000_0103, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tv[11] = '{1'b1, 4'h1, 32'h8000_0100, 32'h0000_00AA, 32'hDEAD_BEAA, 1'b0};
        tv[12] = '{1'b1, 4'h8, 32'h8000_0100, 32'h1234_5678, 32'h12AD_BEAA, 1'b0};
        tv[13] = '{1'b0, 4'h0, 32'h8000_0100, 32'h0,         32'h12AD_BEAA, 1'b0};

        // ---------------- instance 0: latency 1 ----------------
        @(negedge clock);
        cyc();
        chk_reset("rst0");
        rst0 = 1'b0;

        foreach (tv[i]) begin
            drive(1'b1, tv[i].we, tv[i].be, tv[i].a, tv[i].d);
            iaddr = tv[i].a;
            cyc();
            drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            if (tv[i].we) begin
                chk("vec_imem", c_im, tv[i].exp);
            end else begin
                chk1("vec_resp_valid", c_rv, 1'b1);
                chk("vec_resp_data", c_rd, tv[i].exp);
                chk1("vec_resp_err", c_re, tv[i].err);
            end
            cyc();
        end

        for (int n = 0; n < 300; n++) begin
            int          r, wi;
            logic [31:0] a;
            r  = $urandom_range(0, 9);
            wi = 512 + $urandom_range(0, 511);
            a  = BASE + 32'(wi * 4);
            if (r < 4 || (r < 6 && !mw[wi]))
                drive(1'b1, 1'b1, (r == 0) ? 4'($urandom_range(0, 15)) : 4'hF, a, $urandom());
            else if (r < 6)
                drive(1'b1, 1'b0, 4'h0, a + 32'($urandom_range(0, 3)), 32'h0);
            else if (r == 6) begin
                case ($urandom_range(0, 2))
                    0:       a = BASE - 32'd4;
                    1:       a = BASE + 32'(4 * MEM0);
                    default: a = $urandom() & 32'h7FFF_FFFC;
                endcase
                drive(1'b1, 1'b0, 4'h0, a, 32'h0);
            end else
                drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            iaddr = ($urandom_range(0, 3) == 0) ? BASE + 32'(4 * MEM0) + 32'($urandom_range(0, 255))
                                                : BASE + 32'((512 + $urandom_range(0, 511)) * 4);
            cyc();
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        cyc();

        // tohost: first write wins, memory still written, counter freezes
        iaddr = TOHOST;
        drive(1'b1, 1'b1, 4'hF, TOHOST, 32'd1);
        cyc();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk1("tohost_done", c_td, 1'b1);
        chk1("tohost_pass", c_tp, 1'b1);
        chk("tohost_code", c_tc, 32'd1);
        cyc();
        drive(1'b1, 1'b1, 4'hF, TOHOST, 32'd3);
        cyc();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("tohost_code_kept", c_tc, 32'd1);
        chk1("tohost_pass_kept", c_tp, 1'b1);
        chk("tohost_mem_written", c_im, 32'd3);
        begin
            int frozen;
            frozen = m_cnt;
            repeat (5) cyc();
            chk("cycle_count_frozen", c_cc, 32'(frozen));
        end

        // ---------------- instance 1: latency 4, 2 outstanding ----------------
        sel = 1'b1;
        for (int i = 0; i < 2048; i++) mw[i] = 1'b0;
        iaddr = BASE + 32'h40;
        cyc();
        chk_reset("rst1");
        rst1 = 1'b0;

        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 4'hF, BASE + 32'h40 + 32'(4 * k), 32'hA0 + 32'(k));
            cyc();
        end

        begin
            int  k, j;
            bit  a_ok;
            k = 0; j = 0;
            for (int c = 0; c < 40 && (k < 5 || mq.size() > 0); c++) begin
                if (k < 5) drive(1'b1, 1'b0, 4'h0, BASE + 32'h40 + 32'(4 * k), 32'h0);
                else       drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                a_ok = vld && c_rdy;
                cyc();
                if (a_ok) begin acc_e.push_back(c); k++; end
                if (c_rv) begin
                    rsp_e.push_back(c);
                    chk("pipe_order_data", c_rd, 32'hA0 + 32'(j));
                    j++;
                end
            end
            drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            chk("pipe_n_accepted", 32'(acc_e.size()), 32'd5);
            chk("pipe_n_responses", 32'(rsp_e.size()), 32'd5);
            for (int i = 0; i < 5 && i < acc_e.size(); i++)
                chk("pipe_accept_edge", 32'(acc_e[i]), 32'(exp_acc[i]));
            for (int i = 0; i < rsp_e.size() && i < acc_e.size(); i++)
                chk("pipe_latency", 32'(rsp_e[i] - acc_e[i]), 32'(LAT1 - 1));
        end

        repeat (40) cyc();
        chk1("timeout_set", c_to, 1'b1);
        chk("timeout_count", c_cc, 32'd49);
        repeat (3) cyc();
        chk("timeout_count_held", c_cc, 32'd49);

        // reset with two loads in flight
        drive(1'b1, 1'b0, 4'h0, BASE + 32'h40, 32'h0);
        cyc();
        drive(1'b1, 1'b0, 4'h0, BASE + 32'h44, 32'h0);
        cyc();
        chk1("inflight_full_ready", c_rdy, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst1 = 1'b1;
        cyc();
        chk_reset("midrst");
        rst1 = 1'b0;
        repeat (6) begin
            cyc();
            chk1("no_resp_after_reset", c_rv, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
